// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared encodings for the digit-serial ALU: op groups,
//               B-operand selects, logic sub-ops and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Op group, carried in sel[3:2]
    localparam logic [1:0] ARITH = 2'b00;
    localparam logic [1:0] LOGIC = 2'b01;
    localparam logic [1:0] SHR   = 2'b10;
    localparam logic [1:0] SHL   = 2'b11;

    // B-operand select for arithmetic, carried in sel[1:0]
    localparam logic [1:0] BSEL_B    = 2'b00;
    localparam logic [1:0] BSEL_NOTB = 2'b01;
    localparam logic [1:0] BSEL_ZERO = 2'b10;
    localparam logic [1:0] BSEL_ONES = 2'b11;

    // Logic sub-op, carried in sel[1:0]
    localparam logic [1:0] LOG_AND  = 2'b00;
    localparam logic [1:0] LOG_OR   = 2'b01;
    localparam logic [1:0] LOG_XOR  = 2'b10;
    localparam logic [1:0] LOG_NOTA = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_digit.sv
`default_nettype none
// ============================================================================
// Module      : alu_digit
// Description : Combinational DIGIT_W-wide ALU slice (arith/logic) with the
//               carry into its MSB exposed for overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               cin_i,
    input  logic [3:0]         sel_i,
    output logic [DIGIT_W-1:0] f_o,
    output logic               cout_o,
    output logic               c_msb_in_o
);

    logic [DIGIT_W-1:0] w_bsel;
    logic [DIGIT_W:0]   w_sum;

    always_comb begin
        case (sel_i[1:0])
            BSEL_B:    w_bsel = b_i;
            BSEL_NOTB: w_bsel = ~b_i;
            BSEL_ZERO: w_bsel = '0;
            default:   w_bsel = '1;
        endcase

        w_sum = {1'b0, a_i} + {1'b0, w_bsel} + {{DIGIT_W{1'b0}}, cin_i};

        f_o    = '0;
        cout_o = 1'b0;
        case (sel_i[3:2])
            ARITH: begin
                f_o    = w_sum[DIGIT_W-1:0];
                cout_o = w_sum[DIGIT_W];
            end
            LOGIC: begin
                case (sel_i[1:0])
                    LOG_AND:  f_o = a_i & b_i;
                    LOG_OR:   f_o = a_i | b_i;
                    LOG_XOR:  f_o = a_i ^ b_i;
                    default:  f_o = ~a_i;
                endcase
            end
            default: ;
        endcase
    end

    // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the sum.
    assign c_msb_in_o = w_sum[DIGIT_W-1] ^ a_i[DIGIT_W-1] ^ w_bsel[DIGIT_W-1];

endmodule : alu_digit
`default_nettype wire

// File: rtl/alu_serial_nbit.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_nbit
// Description : Digit-serial WIDTH-bit ALU, DIGIT_W bits per cycle, with a
//               start/busy/done handshake. Optional zero/overflow flags are
//               enabled by defining ALU_STATUS_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_nbit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] f_o,
    output logic             cout_o,
    output logic             zero_o,
    output logic             ovf_o
);

    // WIDTH must be a multiple of DIGIT_W and at least 2 bits wide.
    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         sel_q, sel_d;
    logic               carry_q, carry_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic               cout_q, cout_d;

    logic [DIGIT_W-1:0]       w_dig_f;
    logic                     w_dig_cout;
    logic [WIDTH+DIGIT_W-1:0] w_cat;
    logic [WIDTH-1:0]         w_res;
    logic [WIDTH-1:0]         w_shift;
    logic                     w_shift_out;
    logic                     w_last;

`ifdef ALU_STATUS_FLAGS_EN
    logic w_c_msb;
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
`else
    logic w_c_msb_unused;
`endif

    alu_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a_i        (a_q[DIGIT_W-1:0]),
        .b_i        (b_q[DIGIT_W-1:0]),
        .cin_i      (carry_q),
        .sel_i      (sel_q),
        .f_o        (w_dig_f),
        .cout_o     (w_dig_cout),
`ifdef ALU_STATUS_FLAGS_EN
        .c_msb_in_o (w_c_msb)
`else
        .c_msb_in_o (w_c_msb_unused)
`endif
    );

    // Result digits enter at the top of the A register as operand digits leave the bottom.
    assign w_cat  = {w_dig_f, a_q};
    assign w_res  = w_cat[WIDTH+DIGIT_W-1:DIGIT_W];
    assign w_last = (cnt_q == CW'(NDIG - 1));

    assign w_shift     = (sel_q[2]) ? {a_q[WIDTH-2:0], carry_q} : {carry_q, a_q[WIDTH-1:1]};
    assign w_shift_out = (sel_q[2]) ? a_q[WIDTH-1] : a_q[0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        cout_d  = cout_q;
`ifdef ALU_STATUS_FLAGS_EN
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            RUN: begin
                if (sel_q[3]) begin
                    f_d     = w_shift;
                    cout_d  = w_shift_out;
                    state_d = DONE;
`ifdef ALU_STATUS_FLAGS_EN
                    zero_d  = (w_shift == '0);
                    ovf_d   = 1'b0;
`endif
                end else begin
                    a_d     = w_res;
                    b_d     = b_q >> DIGIT_W;
                    carry_d = w_dig_cout;
                    cnt_d   = cnt_q + CW'(1);
                    if (w_last) begin
                        f_d     = w_res;
                        cout_d  = w_dig_cout;
                        state_d = DONE;
`ifdef ALU_STATUS_FLAGS_EN
                        zero_d  = (w_res == '0);
                        ovf_d   = (sel_q[3:2] == ARITH) & (w_c_msb ^ w_dig_cout);
`endif
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                state_d = IDLE;
                if (start_i) begin
                    state_d = RUN;
                    a_d     = a_i;
                    b_d     = b_i;
                    sel_d   = sel_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            f_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
        end
    end

`ifdef ALU_STATUS_FLAGS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero_o = zero_q;
    assign ovf_o  = ovf_q;
`else
    assign zero_o = 1'b0;
    assign ovf_o  = 1'b0;
`endif

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign f_o    = f_q;
    assign cout_o = cout_q;

endmodule : alu_serial_nbit
`default_nettype wire

// File: tb/tb_alu_serial_nbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_nbit
// Description : Directed self-checking bench for alu_serial_nbit, WIDTH=8,
//               DIGIT_W=2. Flag expectations follow ALU_STATUS_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_nbit;

`ifdef ALU_STATUS_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk_i;
    logic       rst_i;
    logic       start_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       cin_i;
    logic [3:0] sel_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] f_o;
    logic       cout_o;
    logic       zero_o;
    logic       ovf_o;

    int n_chk  = 0;
    int n_fail = 0;

    alu_serial_nbit #(
        .WIDTH   (8),
        .DIGIT_W (2)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .sel_i   (sel_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .f_o     (f_o),
        .cout_o  (cout_o),
        .zero_o  (zero_o),
        .ovf_o   (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, wait (bounded) for done_o, then check result and pulse width.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic cin, input int exp_lat,
                         input logic [7:0] ef, input logic ec, input logic ez, input logic ev);
        int lat;
        @(negedge clk_i);
        a_i = a; b_i = b; sel_i = sel; cin_i = cin; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 20) begin
            @(posedge clk_i);
            #1 lat++;
        end
        check({tag, "_lat"},  lat,    exp_lat);
        check({tag, "_f"},    f_o,    ef);
        check({tag, "_cout"}, cout_o, ec);
        check({tag, "_zero"}, zero_o, FLAGS & ez);
        check({tag, "_ovf"},  ovf_o,  FLAGS & ev);
        check({tag, "_busy"}, busy_o, 1'b0);
        @(posedge clk_i);
        #1 check({tag, "_pulse"}, done_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sel_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_f",    f_o,    8'h00);
        check("rst_cout", cout_o, 1'b0);
        check("rst_zero", zero_o, 1'b0);
        check("rst_ovf",  ovf_o,  1'b0);
        rst_i = 1'b0;

        // Arithmetic, including each B-select
        do_op("add",   8'h5A, 8'h3C, 4'b0000, 1'b0, 4, 8'h96, 1'b0, 1'b0, 1'b1);
        do_op("sub",   8'h10, 8'h20, 4'b0001, 1'b1, 4, 8'hF0, 1'b0, 1'b0, 1'b0);
        do_op("wrap",  8'hFF, 8'h01, 4'b0000, 1'b0, 4, 8'h00, 1'b1, 1'b1, 1'b0);
        do_op("inc",   8'h7F, 8'h55, 4'b0010, 1'b1, 4, 8'h80, 1'b0, 1'b0, 1'b1);
        do_op("dec",   8'h05, 8'h00, 4'b0011, 1'b0, 4, 8'h04, 1'b1, 1'b0, 1'b0);

        // Logic
        do_op("and",   8'hF0, 8'hAA, 4'b0100, 1'b1, 4, 8'hA0, 1'b0, 1'b0, 1'b0);
        do_op("or",    8'hF0, 8'hAA, 4'b0101, 1'b0, 4, 8'hFA, 1'b0, 1'b0, 1'b0);
        do_op("xor",   8'hF0, 8'hAA, 4'b0110, 1'b0, 4, 8'h5A, 1'b0, 1'b0, 1'b0);
        do_op("nota",  8'hF0, 8'hAA, 4'b0111, 1'b0, 4, 8'h0F, 1'b0, 1'b0, 1'b0);

        // Shifts
        do_op("shl",   8'h81, 8'h00, 4'b1100, 1'b0, 1, 8'h02, 1'b1, 1'b0, 1'b0);
        do_op("shr",   8'h81, 8'h00, 4'b1000, 1'b1, 1, 8'hC0, 1'b1, 1'b0, 1'b0);

        // Handshake: start held high; ignored while busy, re-accepted in DONE
        @(negedge clk_i);
        a_i = 8'h01; b_i = 8'h02; sel_i = 4'b0000; cin_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        #1 a_i = 8'h10; b_i = 8'h20;
        ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o) ndone++;
            if (c == 2) check("hs_busy1", busy_o, 1'b1);
            if (c == 4) begin
                check("hs_done1", done_o, 1'b1);
                check("hs_f1",    f_o,    8'h03);
            end
            if (c == 5) begin
                check("hs_busy2", busy_o, 1'b1);
                check("hs_hold",  f_o,    8'h03);
                start_i = 1'b0;
            end
            if (c == 9) begin
                check("hs_done2", done_o, 1'b1);
                check("hs_f2",    f_o,    8'h30);
            end
        end
        check("hs_ndone", ndone, 2);

        // Reset in the second RUN cycle aborts the operation
        @(negedge clk_i);
        a_i = 8'h5A; b_i = 8'h3C; sel_i = 4'b0000; cin_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        check("ar_f",    f_o,    8'h00);
        check("ar_cout", cout_o, 1'b0);
        check("ar_busy", busy_o, 1'b0);
        check("ar_done", done_o, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i);
            #1 if (done_o) ndone++;
        end
        check("ar_nodone", ndone, 0);
        do_op("post",  8'h5A, 8'h3C, 4'b0000, 1'b0, 4, 8'h96, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_alu_serial_nbit
`default_nettype wire

// File: doc/alu_serial_nbit.md
Name: alu_serial_nbit

Overview:
Parametrised, digit-serial successor to the 1-bit ALU slice. Computes a WIDTH-bit result DIGIT_W bits per cycle, rippling carry between digits through a register, so one narrow slice serves any width. It keeps the 4-bit select encoding (arith/logic/shift) and adds a start/busy/done handshake plus result flags. It sits between the operand register file and the 32-bit datapath integration.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of DIGIT_W.
DIGIT_W, 4, bits processed per cycle; NDIG = WIDTH/DIGIT_W digits.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  request; accepted only when busy_o=0
a_i  input  WIDTH  operand A, sampled on the accept edge
b_i  input  WIDTH  operand B, sampled on the accept edge
cin_i  input  1  carry-in (arith) / shift fill bit (shift), sampled on the accept edge
sel_i  input  4  operation select, sampled on the accept edge
busy_o  output  1  operation in progress
done_o  output  1  one-cycle pulse when f_o and flags are valid
f_o  output  WIDTH  result; held until the next completion
cout_o  output  1  carry-out / shifted-out bit
zero_o  output  1  f_o == 0 (optional-feature dependent)
ovf_o  output  1  signed overflow (optional-feature dependent)

Behaviour:
- Reset (async assert, sync release): state IDLE; busy_o=0, done_o=0, f_o=0, cout_o=0, zero_o=0, ovf_o=0; internal carry and digit counter cleared. Reset mid-operation aborts it with no done_o.
- FSM states: IDLE -> (start_i) RUN -> (last digit) DONE -> IDLE; DONE -> RUN directly if start_i is high in DONE.
- Accept edge k latches a_i, b_i, sel_i and cin_i. Carry register = cin_i. busy_o=1 from edge k.
- Arith (sel[3:2]=00): operand B' = B (00), ~B (01), 0 (10), all-ones (11); F = A + B' + cin.
- RUN: one digit per edge, LSB digit first. Carry is registered between digits. Result digits shift into the result register.
- At edge k+NDIG: f_o and cout_o update, state=DONE, busy_o=0, done_o=1 for exactly one cycle.
- Logic (sel[3:2]=01): AND, OR, XOR, NOT A for sel[1:0]=00..11. Digit-serial with the same NDIG latency; cout_o=0.
- Shift (sel[3:2]=10 SHR, 11 SHL; sel[1:0] don't care): completes in a single cycle.
  - SHR: F = {cin, A[W-1:1]}, cout = A[0].
  - SHL: F = {A[W-2:0], cin}, cout = A[W-1].
  - done_o at edge k+1.
- Widths: all arithmetic is modulo 2^WIDTH; cout_o = carry out of bit WIDTH-1.
- start_i while busy_o=1 is ignored (no queueing, no error).
- Outputs f_o, cout_o, zero_o and ovf_o change only on completion edges.

Optional Feature:
ALU_STATUS_FLAGS_EN
- Defined:
  - zero_o = (F==0), updated on completion.
  - ovf_o = carry into MSB XOR carry out of MSB, for arith ops only; 0 for logic and shift.
- Undefined: both ports remain present and are tied to 0; no flag logic is synthesised.

Decomposition:
- Shared package alu_pkg:
  - op-group localparams ARITH=2'b00, LOGIC=2'b01, SHR=2'b10, SHL=2'b11.
  - logic sub-op and B-select encodings.
  - FSM state typedef/localparams IDLE/RUN/DONE.
- One sub-module, alu_digit: a combinational DIGIT_W-wide slice with inputs a, b, cin, sel[3:0] and outputs f, cout, c_msb_in (carry into the slice MSB, used for ovf). Instantiated once; the top holds the FSM, counter and shift registers.

Test Plan:
- WIDTH=8, DIGIT_W=2: A=0x5A, B=0x3C, sel=0000, cin=0 -> after 4 cycles done_o pulse, f_o=0x96, cout_o=0, ovf_o=1, zero_o=0.
- A=0x10, B=0x20, sel=0001, cin=1 (subtract) -> f_o=0xF0, cout_o=0, ovf_o=0. Then A=0xFF, B=0x01, sel=0000 -> f_o=0x00, cout_o=1, zero_o=1.
- Logic: A=0xF0, B=0xAA with sel=0100/0101/0110/0111 -> f_o=0xA0/0xFA/0x5A/0x0F, cout_o=0, latency 4.
- Shift: A=0x81, sel=1100, cin=0 -> f_o=0x02, cout_o=1, done_o 1 cycle after accept. A=0x81, sel=1000, cin=1 -> f_o=0xC0, cout_o=1.
- Handshake: start_i held high through a run -> second start ignored while busy, re-accepted in the DONE cycle, back-to-back results correct, one done_o per op.
- Reset asserted in the 2nd RUN cycle -> all outputs 0 immediately; no done_o; next op after release is correct.
